// File: rtl/d_reg_rr_arbiter.sv
// d_reg_rr_arbiter
//
// Purpose:
//   Lets NREQ requesters share one WIDTH-bit register. A round-robin arbiter
//   grants one requester at a time, and the granted data is loaded into the
//   register. After each write the block stays busy for HOLD cycles before it
//   can grant again. Consumers read q and use q_valid/q_owner to qualify it.
//
// Ports:
//   clk      in   1             rising-edge clock
//   rst      in   1             asynchronous, active-high reset
//   req      in   NREQ          per-requester write request (bit i = requester i)
//   wdata    in   NREQ*WIDTH    write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      out  NREQ          one-hot combinational grant
//   q        out  WIDTH         shared register contents
//   q_valid  out  1             one-cycle pulse the cycle after a write
//   q_owner  out  clog2(NREQ)   index of the requester that last wrote q
//   busy     out  1             high while holding off after a write

module d_reg_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(NREQ)-1:0]    q_owner,
  output logic                       busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = 4;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   ptr_next;
  logic [OW-1:0]   sel;
  logic            found;
  logic [2*NREQ-1:0] rot;
  int              off;
  int              sum;

  // Round-robin pick. Duplicating req and shifting it right by ptr puts the
  // requester at ptr in bit 0, so the lowest set bit of the rotated vector is
  // the first requester in round-robin order. Adding ptr back (mod NREQ)
  // turns that offset into a requester index. Because the scan covers only
  // offsets 0..NREQ-1, an index of NREQ or more can never be selected.
  always_comb begin
    rot   = {req, req} >> ptr;
    found = 1'b0;
    off   = 0;
    sum   = 0;
    sel   = '0;
    gnt   = '0;
    if (!rst && state == ST_IDLE) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (rot[k]) begin
          found = 1'b1;
          off   = k;
        end
      end
      sum = int'(ptr) + off;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      sel = OW'(sum);
      if (found) begin
        gnt = NREQ'(1) << sel;
      end
    end
  end

  // The pointer advances to the requester after the winner. It wraps to 0 on
  // the last index so that non-power-of-two NREQ stays in range.
  always_comb begin
    ptr_next = sel + OW'(1);
    if (sel == OW'(NREQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Next-state logic for the hold-off FSM. A grant loads the counter with
  // HOLD. The HOLD state lasts until the counter reaches 1, which gives
  // exactly HOLD busy cycles. When HOLD is 0, the FSM never leaves IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (found && HOLD > 0) begin
          state_next = ST_HOLD;
          cnt_next   = CW'(HOLD);
        end
      end
      ST_HOLD: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Shared register and bookkeeping. When there is no grant, q, q_owner and
  // ptr keep their values and only the q_valid pulse drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_owner <= '0;
      ptr     <= '0;
    end else begin
      q_valid <= found;
      if (found) begin
        q       <= wdata[int'(sel)*WIDTH +: WIDTH];
        q_owner <= sel;
        ptr     <= ptr_next;
      end
    end
  end

  assign busy = (state == ST_HOLD);

endmodule
